// File: rtl/video_out_adapter.sv
// Purpose: adapt a retro-core video stream (narrow RGB, blanks, syncs, pixel enable)
//          to a 24-bit scaler feed with data enable, skip, sync pulses and counters.
// Latency: 1 clk on every output; there is no backpressure, and skip tells the scaler which cycles to drop.
module video_out_adapter #(
  parameter int COLOR_BITS     = 4,
  parameter int EXPAND         = 1,
  parameter int CE_STRETCH     = 2,
  parameter int HS_ACTIVE_HIGH = 1,
  parameter int VS_ACTIVE_HIGH = 1,
  parameter int LINE_W         = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COLOR_BITS-1:0] r_in,
  input  logic [COLOR_BITS-1:0] g_in,
  input  logic [COLOR_BITS-1:0] b_in,
  input  logic                  hblank_in,
  input  logic                  vblank_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  ce_pixel,
  output logic [23:0]           rgb,
  output logic                  de,
  output logic                  skip,
  output logic                  hs,
  output logic                  vs,
  output logic [LINE_W-1:0]     line_count,
  output logic [7:0]            frame_count
);

  // Active sync levels as single bits, so that the input comparisons below stay one bit wide.
  localparam logic HS_ACT = (HS_ACTIVE_HIGH != 0);
  localparam logic VS_ACT = (VS_ACTIVE_HIGH != 0);

  // The value the stretch counter takes on each pixel enable. It needs 4 bits because CE_STRETCH can be up to 15.
  localparam logic [3:0] CE_LOAD = 4'(CE_STRETCH - 1);

  // The largest line_count value. The counter stops here and does not wrap.
  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  // Widen one channel to 8 bits. In replicate mode the bits repeat MSB-first, which maps full scale
  // onto 8'hFF. In zero-pad mode the channel is left-justified. At 8 bits both modes return the input.
  function automatic logic [7:0] expand_chan(input logic [COLOR_BITS-1:0] c);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (EXPAND != 0) begin
        res[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
      end else if (i < COLOR_BITS) begin
        res[7-i] = c[COLOR_BITS-1-i];
      end
    end
    return res;
  endfunction

  logic              de_next;
  logic [23:0]       rgb_next;
  logic [3:0]        ce_cnt;
  logic [3:0]        ce_cnt_next;
  logic              ce_held;
  logic              skip_next;
  logic              hs_hist;
  logic              vs_hist;
  logic              hs_next;
  logic              vs_next;
  logic [LINE_W-1:0] line_next;

  // Next-cycle values for every output, computed from the current inputs and the held state.
  always_comb begin
    de_next  = !(hblank_in | vblank_in);
    rgb_next = '0;
    if (de_next) begin
      rgb_next = {expand_chan(r_in), expand_chan(g_in), expand_chan(b_in)};
    end

    // A new pixel enable reloads the counter rather than adding to it, so stretches never pile up.
    ce_cnt_next = '0;
    if (ce_pixel) begin
      ce_cnt_next = CE_LOAD;
    end else if (ce_cnt != 4'd0) begin
      ce_cnt_next = ce_cnt - 4'd1;
    end
    ce_held   = ce_pixel | (ce_cnt != 4'd0);
    skip_next = de_next & !ce_held;

    // A sync pulse is an inactive-to-active edge, measured against last cycle's raw input.
    hs_next = (hsync_in == HS_ACT) && (hs_hist != HS_ACT);
    vs_next = (vsync_in == VS_ACT) && (vs_hist != VS_ACT);

    // When both pulses fall in the same cycle, the frame start wins and the line increment is dropped.
    line_next = line_count;
    if (vs_next) begin
      line_next = '0;
    end else if (hs_next && (line_count != LINE_MAX)) begin
      line_next = line_count + 1'b1;
    end
  end

  // Output and state registers. During reset the sync history holds the active level,
  // so a sync that is already asserted when reset releases is not seen as a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb         <= '0;
      de          <= 1'b0;
      skip        <= 1'b0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      line_count  <= '0;
      frame_count <= '0;
      ce_cnt      <= '0;
      hs_hist     <= HS_ACT;
      vs_hist     <= VS_ACT;
    end else begin
      rgb         <= rgb_next;
      de          <= de_next;
      skip        <= skip_next;
      hs          <= hs_next;
      vs          <= vs_next;
      line_count  <= line_next;
      frame_count <= vs_next ? frame_count + 8'd1 : frame_count;
      ce_cnt      <= ce_cnt_next;
      hs_hist     <= hsync_in;
      vs_hist     <= vsync_in;
    end
  end

endmodule
